// File: rtl/msx_cycle_sched.sv
// Two-requester MSX bus cycle scheduler: round-robin arbitration, then a
// SETUP/STROBE/HOLD bus cycle with mwait extension and abort on timeout.
module msx_cycle_sched #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int WAIT_MAX   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  wr,
  input  logic [1:0]  io,
  input  logic [1:0]  slot,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] maddr,
  output logic [7:0]  mdout,
  output logic        mdoe,
  input  logic [7:0]  mdin,
  input  logic        mwait,
  output logic        mrd,
  output logic        mwr,
  output logic        mmreq,
  output logic        miorq,
  output logic        msltsl1,
  output logic        msltsl2
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LIM    = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  ext_q, ext_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d, io_q, io_d, slot_q, slot_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        abort_q, abort_d;
  logic        gnt_fire, done_fire, capture;
  logic        pick, active;

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  assign pick   = (req == 2'b11) ? ~last_q : req[1];
  assign active = (state_d != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    win_d     = win_q;
    last_d    = last_q;
    wr_d      = wr_q;
    io_d      = io_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    abort_d   = abort_q;
    gnt_fire  = 1'b0;
    done_fire = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d  = SETUP;
          cnt_d    = 4'd0;
          ext_d    = 8'd0;
          abort_d  = 1'b0;
          win_d    = pick;
          last_d   = pick;
          wr_d     = pick ? wr[1]   : wr[0];
          io_d     = pick ? io[1]   : io[0];
          slot_d   = pick ? slot[1] : slot[0];
          addr_d   = pick ? addr1   : addr0;
          wdata_d  = pick ? wdata1  : wdata0;
          gnt_fire = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        // Only the final strobe cycle looks at mwait.
        if (cnt_q != STROBE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!mwait) begin
          if (ext_q == WAIT_LIM) begin
            abort_d = 1'b1;
            state_d = HOLD;
            cnt_d   = 4'd0;
          end else begin
            ext_d = ext_q + 8'd1;
          end
        end else begin
          capture = 1'b1;
          state_d = HOLD;
          cnt_d   = 4'd0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          done_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ext_q   <= 8'd0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      slot_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      win_q   <= win_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      io_q    <= io_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
    end
  end

  // Bus outputs are decoded from next state so each is a clean flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= 2'b00;
      done    <= 2'b00;
      err     <= 1'b0;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      mdoe    <= 1'b0;
      mrd     <= 1'b1;
      mwr     <= 1'b1;
      mmreq   <= 1'b1;
      miorq   <= 1'b1;
      msltsl1 <= 1'b1;
      msltsl2 <= 1'b1;
    end else begin
      gnt     <= gnt_fire  ? (win_d ? 2'b10 : 2'b01) : 2'b00;
      done    <= done_fire ? (win_q ? 2'b10 : 2'b01) : 2'b00;
      err     <= done_fire & abort_q;
      if (capture) begin
        rdata <= mdin;
      end
      busy    <= active;
      mdoe    <= active & wr_d;
      mrd     <= ~((state_d == STROBE) & ~wr_d);
      mwr     <= ~((state_d == STROBE) & wr_d);
      mmreq   <= ~(active & ~io_d);
      miorq   <= ~(active & io_d);
      msltsl1 <= ~(active & ~io_d & ~slot_d);
      msltsl2 <= ~(active & ~io_d & slot_d);
    end
  end

  assign maddr = addr_q;
  assign mdout = wdata_q;

endmodule
